// File: rtl/cm_arbiter_pkg.sv
// cm_arbiter_pkg: shared FSM encoding, timeout terminal count and one-hot helper
package cm_arbiter_pkg;

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} arb_state_t;

    localparam int TMO_W_DEF = 4;

    function automatic int tmo_term(input int w);
        return (1 << w) - 1;
    endfunction

    function automatic logic [2:0] oh2idx(input logic [7:0] oh);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < 8; i++)
            if (oh[i]) idx = 3'(i);
        return idx;
    endfunction

endpackage

// File: rtl/cm_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker; first request above last (mod NREQ) wins
module rr_pick #(
    parameter int NREQ = 3,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last,
    output logic [NREQ-1:0] gnt
);

    int j;

    // scan from farthest to nearest so the nearest candidate overwrites
    always_comb begin
        gnt = '0;
        j = 0;
        for (int i = NREQ; i >= 1; i--) begin
            j = (int'(last) + i) % NREQ;
            if (req[j]) gnt = NREQ'(1) << j;
        end
    end

endmodule

// File: rtl/cm_arbiter.sv
// cm_arbiter: round-robin owner of the communication-memory WISHBONE port,
// grant held for the whole CYC burst, with an ACK timeout that raises ERR.
module cm_arbiter import cm_arbiter_pkg::*; #(
    parameter int NREQ  = 3,
    parameter int CM_AW = 16,
    parameter int CM_DW = 32,
    parameter int TMO_W = TMO_W_DEF
) (
    input  logic                  CLK_i,
    input  logic                  RST_i,
    input  logic [NREQ-1:0]       M_CYC_i,
    input  logic [NREQ-1:0]       M_STB_i,
    input  logic [NREQ-1:0]       M_WE_i,
    input  logic [2*NREQ-1:0]     M_SEL_i,
    input  logic [NREQ*CM_AW-1:0] M_ADR_i,
    input  logic [NREQ*CM_DW-1:0] M_DAT_i,
    output logic [CM_DW-1:0]      M_DAT_o,
    output logic [NREQ-1:0]       M_ACK_o,
    output logic [NREQ-1:0]       M_ERR_o,
    output logic [CM_DW-1:0]      CM_DAT_o,
    output logic                  CM_SEL0_o,
    output logic                  CM_SEL1_o,
    output logic                  CM_WE_o,
    output logic                  CM_STB_o,
    output logic [CM_AW-1:0]      CM_ADR_o,
    input  logic [CM_DW-1:0]      CM_DAT_i,
    input  logic                  CM_ACK_i,
    output logic [NREQ-1:0]       gnt_o,
    output logic                  tmo_o
);

    localparam int IW = $clog2(NREQ);
    localparam logic [TMO_W-1:0] TMO_HIT = TMO_W'(tmo_term(TMO_W) - 1);

    arb_state_t       state, state_n;
    logic [NREQ-1:0]  gnt_n, pick;
    logic [IW-1:0]    last, last_n;
    logic [TMO_W-1:0] cnt;
    logic             stb_raw;

    rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (.req(M_CYC_i), .last(last), .gnt(pick));

    always_comb begin
        state_n = state;
        gnt_n   = gnt_o;
        last_n  = last;
        if (state == IDLE && |M_CYC_i) begin
            state_n = BUSY;
            gnt_n   = pick;
            last_n  = IW'(oh2idx(8'(pick)));
        end else if (state == BUSY && !(|(M_CYC_i & gnt_o))) begin
            state_n = IDLE;
            gnt_n   = '0;
        end
    end

    // AND-OR mux on the one-hot grant: everything is zero while no grant is held
    always_comb begin
        CM_ADR_o  = '0;
        CM_DAT_o  = '0;
        CM_WE_o   = 1'b0;
        CM_SEL0_o = 1'b0;
        CM_SEL1_o = 1'b0;
        stb_raw   = 1'b0;
        for (int k = 0; k < NREQ; k++)
            if (gnt_o[k]) begin
                CM_ADR_o  = M_ADR_i[k*CM_AW +: CM_AW];
                CM_DAT_o  = M_DAT_i[k*CM_DW +: CM_DW];
                CM_WE_o   = M_WE_i[k];
                CM_SEL0_o = M_SEL_i[2*k];
                CM_SEL1_o = M_SEL_i[2*k+1];
                stb_raw   = M_STB_i[k] & M_CYC_i[k];
            end
    end

    assign CM_STB_o = stb_raw & ~tmo_o;
    assign M_ACK_o  = gnt_o & {NREQ{CM_ACK_i & CM_STB_o}};
    assign M_ERR_o  = gnt_o & {NREQ{tmo_o}};
    assign M_DAT_o  = RST_i ? CM_DAT_i : '0;

    always_ff @(posedge CLK_i or negedge RST_i) begin
        if (!RST_i) begin
            state <= IDLE;
            gnt_o <= '0;
            last  <= IW'(NREQ - 1);
            cnt   <= '0;
            tmo_o <= 1'b0;
        end else begin
            state <= state_n;
            gnt_o <= gnt_n;
            last  <= last_n;
            cnt   <= (!CM_STB_o || CM_ACK_i || cnt == TMO_HIT) ? '0 : cnt + 1'b1;
            tmo_o <= CM_STB_o && !CM_ACK_i && cnt == TMO_HIT;
        end
    end

endmodule

// File: tb/tb_cm_arbiter.sv
// tb_cm_arbiter: directed and randomized checks of cm_arbiter against a behavioural model
module tb_cm_arbiter;

    localparam int N  = 3;
    localparam int AW = 16;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [N-1:0]  cyc = '0, stb = '0, we = '0;
    logic [2*N-1:0] sel = '0;
    logic [N*AW-1:0] adr = '0;
    logic [N*DW-1:0] dat = '0;
    logic [DW-1:0] cm_dat_i = '0;
    logic          cm_ack_i = 1'b0;
    logic [DW-1:0] m_dat, cm_dat_o;
    logic [N-1:0]  m_ack, m_err, gnt;
    logic          sel0, sel1, cm_we, cm_stb, tmo;
    logic [AW-1:0] cm_adr;

    int checks = 0;
    int errors = 0;
    int owner = -1;
    int last = N - 1;
    int wt = 0;
    bit merr = 1'b0;
    int ack_own = -1;
    logic [N-1:0] prev_g;
    logic [N-1:0] order[$];

    always #5 clk = ~clk;

    cm_arbiter #(.NREQ(N), .CM_AW(AW), .CM_DW(DW), .TMO_W(4)) dut (
        .CLK_i(clk), .RST_i(rst_n),
        .M_CYC_i(cyc), .M_STB_i(stb), .M_WE_i(we), .M_SEL_i(sel),
        .M_ADR_i(adr), .M_DAT_i(dat), .M_DAT_o(m_dat),
        .M_ACK_o(m_ack), .M_ERR_o(m_err),
        .CM_DAT_o(cm_dat_o), .CM_SEL0_o(sel0), .CM_SEL1_o(sel1),
        .CM_WE_o(cm_we), .CM_STB_o(cm_stb), .CM_ADR_o(cm_adr),
        .CM_DAT_i(cm_dat_i), .CM_ACK_i(cm_ack_i),
        .gnt_o(gnt), .tmo_o(tmo)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        owner = -1;
        last  = N - 1;
        wt    = 0;
        merr  = 1'b0;
    endtask

    // compare every output with the model, then advance the model over one edge
    task automatic tick();
        logic [N-1:0] e_gnt, e_ack, e_err;
        logic e_stb;
        int g;
        #1;
        g     = owner < 0 ? 0 : owner;
        e_gnt = owner >= 0 ? N'(1) << owner : '0;
        e_stb = owner >= 0 && cyc[g] && stb[g] && !merr;
        e_ack = (e_stb && cm_ack_i) ? e_gnt : '0;
        e_err = merr ? e_gnt : '0;
        chk("gnt", 32'(gnt), 32'(e_gnt));
        chk("cm_stb", 32'(cm_stb), 32'(e_stb));
        chk("m_ack", 32'(m_ack), 32'(e_ack));
        chk("m_err", 32'(m_err), 32'(e_err));
        chk("tmo", 32'(tmo), 32'(merr));
        chk("cm_adr", 32'(cm_adr), owner >= 0 ? 32'(adr[g*AW +: AW]) : 32'h0);
        chk("cm_dat", cm_dat_o, owner >= 0 ? dat[g*DW +: DW] : 32'h0);
        chk("cm_we", 32'(cm_we), owner >= 0 ? 32'(we[g]) : 32'h0);
        chk("sel0", 32'(sel0), owner >= 0 ? 32'(sel[2*g]) : 32'h0);
        chk("sel1", 32'(sel1), owner >= 0 ? 32'(sel[2*g+1]) : 32'h0);
        chk("m_dat", m_dat, rst_n ? cm_dat_i : 32'h0);
        ack_own = (|e_ack) ? owner : -1;
        @(posedge clk);
        if (!rst_n) model_reset();
        else if (owner < 0) begin
            for (int i = N; i >= 1; i--)
                if (cyc[(last + i) % N]) owner = (last + i) % N;
            if (owner >= 0) last = owner;
            wt = 0;
            merr = 1'b0;
        end else begin
            wt = (e_stb && !cm_ack_i) ? wt + 1 : 0;
            merr = (wt == 15);
            if (merr) wt = 0;
            if (!cyc[owner]) owner = -1;
        end
        @(negedge clk);
    endtask

    initial begin
        cyc = '1; stb = '1; we = '1; sel = '1; adr = '1; dat = '1;
        cm_dat_i = 32'hDEAD_BEEF; cm_ack_i = 1'b1;
        @(negedge clk);
        tick();
        tick();

        rst_n = 1'b1;
        cyc = '0; stb = '1; we = '0; sel = '0; adr = '0; dat = '0;
        tick();
        prev_g = '0;
        for (int c = 0; c < 12; c++) begin
            cyc = '1;
            if (ack_own >= 0) cyc[ack_own] = 1'b0;
            if (gnt != '0 && gnt != prev_g) order.push_back(gnt);
            prev_g = gnt;
            tick();
        end
        chk("rr_count", 32'(order.size()), 32'd4);
        chk("rr_first", 32'(order[0]), 32'h1);
        chk("rr_second", 32'(order[1]), 32'h2);
        chk("rr_third", 32'(order[2]), 32'h4);
        chk("rr_fourth", 32'(order[3]), 32'h1);
        cyc = '0;
        tick();
        tick();

        stb = 3'b011; we = 3'b011; sel = 6'b00_11_01; cm_ack_i = 1'b1; cyc = 3'b011;
        adr[0 +: AW] = 16'h0100;
        tick();
        chk("burst_gnt", 32'(gnt), 32'h2);
        for (int i = 0; i < 4; i++) begin
            adr[AW +: AW] = 16'h0010 + AW'(i);
            dat[DW +: DW] = 32'hA5A5_0000 + DW'(i);
            #1;
            chk("burst_adr", 32'(cm_adr), 32'h10 + 32'(i));
            chk("burst_dat", cm_dat_o, 32'hA5A5_0000 + 32'(i));
            chk("burst_ack", 32'(m_ack), 32'h2);
            tick();
        end
        cyc[1] = 1'b0;
        tick();
        chk("burst_dead", 32'(gnt), 32'h0);
        tick();
        chk("burst_next", 32'(gnt), 32'h1);
        cyc = '0;
        tick();
        tick();

        cyc = 3'b100; stb = 3'b100; we = '0; cm_ack_i = 1'b0;
        cm_dat_i = 32'h1234_5678; adr[2*AW +: AW] = 16'h0042;
        tick();
        chk("rd_gnt", 32'(gnt), 32'h4);
        for (int i = 0; i < 3; i++) begin
            #1 chk("rd_wait", 32'(m_ack), 32'h0);
            tick();
        end
        cm_ack_i = 1'b1;
        #1;
        chk("rd_ack", 32'(m_ack), 32'h4);
        chk("rd_dat", m_dat, 32'h1234_5678);
        tick();
        cm_ack_i = 1'b0; stb = '0;
        #1 chk("rd_once", 32'(m_ack), 32'h0);
        tick();
        cyc = '0;
        tick();
        tick();

        cyc = 3'b100; stb = 3'b100; cm_ack_i = 1'b0;
        tick();
        for (int i = 0; i < 15; i++) begin
            #1;
            chk("tmo_stb", 32'(cm_stb), 32'h1);
            chk("tmo_quiet", 32'(m_err), 32'h0);
            tick();
        end
        #1;
        chk("tmo_err", 32'(m_err), 32'h4);
        chk("tmo_pulse", 32'(tmo), 32'h1);
        chk("tmo_stb_low", 32'(cm_stb), 32'h0);
        chk("tmo_keep", 32'(gnt), 32'h4);
        tick();
        #1;
        chk("tmo_once", 32'(tmo), 32'h0);
        chk("tmo_restb", 32'(cm_stb), 32'h1);
        tick();

        cyc = 3'b111; stb = 3'b111; we = 3'b111; adr[2*AW +: AW] = 16'hBEEF;
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_stb", 32'(cm_stb), 32'h0);
        chk("rst_adr", 32'(cm_adr), 32'h0);
        chk("rst_we", 32'(cm_we), 32'h0);
        model_reset();
        @(negedge clk);
        tick();
        rst_n = 1'b1;
        tick();
        chk("rst_first", 32'(gnt), 32'h1);

        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(3) == 0) cyc = N'($urandom);
            stb = N'($urandom);
            we = N'($urandom);
            sel = (2*N)'($urandom);
            adr = (N*AW)'({$urandom(), $urandom()});
            dat = (N*DW)'({$urandom(), $urandom(), $urandom()});
            cm_dat_i = $urandom;
            cm_ack_i = ($urandom_range(3) != 0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cm_arbiter.md
# cm_arbiter

Round-robin arbiter that shares the single WISHBONE master port to the SpaceWire communication memory (COMI side, dual-port RAM) among `NREQ` internal requesters: channel TX-fetch and RX-store engines plus host-initiated transfers. It grants one requester at a time and holds the grant for the whole `CYC` burst. It forwards that requester's strobe, address, data and select lanes to the memory and returns `ACK` or a timeout `ERR`. It sits between the per-channel glue logic and the `CM_*` memory bus.

## Interface
Parameters:
- `NREQ`, 3: number of requesters (2..8).
- `CM_AW`, 16: memory address width.
- `CM_DW`, 32: memory data width.
- `TMO_W`, 4: ACK-timeout counter width; timeout fires after `2**TMO_W-1` unacknowledged strobe cycles.

Ports:
- `CLK_i`, in, 1: the single clock; all state is updated on its rising edge.
- `RST_i`, in, 1: asynchronous, active-low reset.
- `M_CYC_i`, in, `NREQ`: per-requester bus cycle request.
- `M_STB_i`, in, `NREQ`: per-requester strobe.
- `M_WE_i`, in, `NREQ`: per-requester write enable.
- `M_SEL_i`, in, `2*NREQ`: {SEL1,SEL0} lanes; requester k uses bits [2k+1:2k].
- `M_ADR_i`, in, `NREQ*CM_AW`: address; requester k uses slice k.
- `M_DAT_i`, in, `NREQ*CM_DW`: write data; requester k uses slice k.
- `M_DAT_o`, out, `CM_DW`: read data, `CM_DAT_i` broadcast to all requesters.
- `M_ACK_o`, out, `NREQ`: acknowledge, granted requester only.
- `M_ERR_o`, out, `NREQ`: one-cycle timeout error, granted requester only.
- `CM_DAT_o`, out, `CM_DW`; `CM_SEL0_o`, out, 1; `CM_SEL1_o`, out, 1; `CM_WE_o`, out, 1; `CM_STB_o`, out, 1; `CM_ADR_o`, out, `CM_AW`: memory bus outputs.
- `CM_DAT_i`, in, `CM_DW`; `CM_ACK_i`, in, 1: memory bus inputs.
- `gnt_o`, out, `NREQ`: one-hot registered grant (status/debug).
- `tmo_o`, out, 1: timeout event pulse for the host interrupt logic.

## Operation
- Two-state FSM.
  - IDLE: `gnt_o`=0. If any `M_CYC_i` bit is set, pick the first set bit searching upward from `last+1` modulo `NREQ`. Register that one-hot grant, update `last`, and go to BUSY.
  - BUSY: the memory outputs are a mux of the granted requester's inputs. If the granted requester's `M_CYC_i` is low at a clock edge, clear `gnt_o` and return to IDLE.
- `CM_STB_o` = `M_STB_i[g] & M_CYC_i[g]` in BUSY, 0 otherwise. `CM_WE_o`, `CM_SEL*`, `CM_ADR_o` and `CM_DAT_o` are muxed from requester g and are all zero when no grant is held.
- `M_ACK_o[g]` = `CM_ACK_i & CM_STB_o`. `CM_ACK_i` is ignored when `CM_STB_o` is low. Non-granted `ACK`/`ERR` bits are always 0.
- Timeout counter:
  - Increments on each cycle where `CM_STB_o`=1 and `CM_ACK_i`=0.
  - Clears on `ACK`, on `CM_STB_o`=0, and on leaving BUSY.
  - At `2**TMO_W-1`: assert `M_ERR_o[g]` and `tmo_o` for one cycle, force `CM_STB_o` low in that cycle, clear the counter. The grant is kept; the requester decides whether to retry or drop `CYC`.
- Simultaneous requests: round-robin order only, no fixed priority. New requests arriving during BUSY wait.
- Reset (asserted at any time, including mid-burst): FSM goes to IDLE, `gnt_o`=0, counter=0, `last`=`NREQ-1` (requester 0 wins first). All outputs are 0 while reset is asserted.

## Timing
- Arbitration latency: `CYC` seen in IDLE at edge n gives grant valid after edge n; `CM_STB_o` can be high in cycle n+1.
- The `ACK` path is combinational (`CM_ACK_i` to `M_ACK_o`), so a zero-wait-state memory completes one transfer per cycle within a burst.
- Release: `CYC` low at edge m gives IDLE after m and new arbitration at edge m+1. This leaves one dead cycle between owners; back-to-back different-owner strobes are never adjacent.
- `gnt_o` and `tmo_o` are registered. `M_ERR_o` is registered from the counter-terminal condition.

## Structure
- Shared package holds:
  - FSM state encoding (IDLE=0, BUSY=1).
  - The `TMO_W`-derived terminal-count constant.
  - A one-hot-to-index function.
- One natural sub-module, `rr_pick`: combinational round-robin picker taking `req[NREQ]` and `last` and producing a one-hot grant.
- Everything else lives in `cm_arbiter`: FSM, mux, timeout counter.

## Test plan
- After reset release, with `M_CYC_i`=3'b111 held:
  - grants occur in order 0, 1, 2, 0, as each owner drops `CYC` after one acked transfer;
  - one idle cycle separates each grant.
- Requester 1 bursts 4 writes (ADR 0x0010..0x0013, DAT 0xA5A5_0000+i) with `CM_ACK_i` tied high:
  - four consecutive `CM_STB_o`/`M_ACK_o[1]` cycles with matching `CM_ADR_o`/`CM_DAT_o`;
  - requester 0 requesting concurrently waits for the burst to finish.
- Read from requester 2 with `CM_DAT_i`=0x1234_5678 and `ACK` after 3 wait states: `M_ACK_o[2]` is high for one cycle with `M_DAT_o`=0x1234_5678.
- `CM_ACK_i` held low with `TMO_W`=4: after 15 strobe cycles, `M_ERR_o[g]` and `tmo_o` pulse once, `CM_STB_o` is low in that cycle, and the grant is retained.
- `RST_i` pulled low mid-burst: all `CM_*` outputs and `gnt_o` go 0 immediately. After release, requester 0 wins first even if requester 2 held the grant before reset.
